// File: rtl/display_shift_sequencer.sv
// Serialises a 32-bit, four-digit segment frame MSB first into a shift register (data/clock/latch).
// Optional DISPLAY_AUTO_REFRESH_EN: re-sends the last captured frame after REFRESH_CYCLES idle cycles.
module display_shift_sequencer #(
  parameter int SYS_CLK_HZ     = 5_000_000,
  parameter int SHIFT_CLK_HZ   = 1_000_000,
  parameter int REFRESH_CYCLES = 50_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_start,
  input  logic [31:0] i_frame,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_serial_data,
  output logic        o_serial_clk,
  output logic        o_serial_latch
);

  localparam int DIV      = SYS_CLK_HZ / SHIFT_CLK_HZ;
  localparam int PW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int HI_START = DIV - DIV / 2;
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HI   = PW'(HI_START);

  generate
    if (DIV < 2 || REFRESH_CYCLES < 1) begin : g_bad_cfg
      $error("display_shift_sequencer: DIV must be >= 2 and REFRESH_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [4:0]    bit_cnt, bit_nxt;
  logic [31:0]   hold;
  logic          done_q, done_nxt;
  logic          accept, refresh, go;

  // Frames only start from IDLE; anything arriving while busy is dropped.
  assign accept = (state == IDLE) && i_start && i_en;
  assign go     = accept || ((state == IDLE) && refresh);

`ifdef DISPLAY_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  logic [RW-1:0] idle_cnt;
  logic          idle_qual;

  assign idle_qual = (state == IDLE) && i_en && !i_start;
  assign refresh   = idle_qual && (idle_cnt == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                   idle_cnt <= '0;
    else if (idle_qual && !refresh) idle_cnt <= idle_cnt + 1'b1;
    else                           idle_cnt <= '0;
  end
`else
  assign refresh = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      hold    <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_nxt;
      done_q  <= done_nxt;
      if (accept) hold <= i_frame;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = SHIFT;
          phase_nxt = '0;
          bit_nxt   = '0;
        end
      end
      SHIFT: begin
        if (phase == PH_LAST) begin
          phase_nxt = '0;
          if (bit_cnt == 5'd31) state_nxt = LATCH;
          else                  bit_nxt   = bit_cnt + 5'd1;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      LATCH: begin
        if (phase == PH_LAST) begin
          state_nxt = IDLE;
          phase_nxt = '0;
          done_nxt  = 1'b1;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from reset-cleared state so they drop with reset, no clock needed.
  assign o_busy         = (state == SHIFT) || (state == LATCH);
  assign o_done         = done_q;
  assign o_serial_data  = (state == SHIFT) && hold[5'd31 - bit_cnt];
  assign o_serial_clk   = (state == SHIFT) && (phase >= PH_HI);
  assign o_serial_latch = (state == LATCH);

endmodule

// File: tb/tb_display_shift_sequencer.sv
// Randomised bench for display_shift_sequencer; a frame-timeline reference model predicts all outputs every cycle.
module tb_display_shift_sequencer;
  localparam int SYS       = 5_000_000;
  localparam int SHF       = 1_000_000;
  localparam int DIV       = SYS / SHF;
  localparam int RC        = 100;
  localparam int SHIFT_LEN = 32 * DIV;
  localparam int FRAME_LEN = 33 * DIV;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_en = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_frame = '0;
  logic        o_busy, o_done, o_serial_data, o_serial_clk, o_serial_latch;

  display_shift_sequencer #(
    .SYS_CLK_HZ(SYS), .SHIFT_CLK_HZ(SHF), .REFRESH_CYCLES(RC)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_start(i_start), .i_frame(i_frame),
    .o_busy(o_busy), .o_done(o_done), .o_serial_data(o_serial_data),
    .o_serial_clk(o_serial_clk), .o_serial_latch(o_serial_latch)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, t);
    end
  endtask

  function automatic logic [4:0] outs();
    return {o_busy, o_done, o_serial_data, o_serial_clk, o_serial_latch};
  endfunction

  // Model: a frame started (sampled) at cycle s shifts bit k over cycles s+1+k*DIV .. s+(k+1)*DIV,
  // latches for the next DIV cycles and reports done at s+1+33*DIV, which is itself an idle cycle.
  bit          act = 1'b0;
  int          s = 0;
  logic [31:0] f = '0;
  logic [31:0] last = '0;
  int          ic = 0;

  initial begin : model
    int       d, b, p;
    bit       idle;
    logic [4:0] e;
    forever begin
      @(negedge i_clk);
      t++;
      if (i_reset) begin
        act = 1'b0; last = '0; ic = 0;
        chk("reset_outs", 32'(outs()), 32'd0);
      end else begin
        e = '0;
        d = t - s;
        if (act && d >= 1 && d <= SHIFT_LEN) begin
          b = (d - 1) / DIV;
          p = (d - 1) % DIV;
          e = {1'b1, 1'b0, f[31 - b], (p >= DIV - DIV / 2), 1'b0};
        end else if (act && d > SHIFT_LEN && d <= FRAME_LEN) begin
          e = 5'b10001;
        end else if (act && d == FRAME_LEN + 1) begin
          e = 5'b01000;
        end
        chk("outs{busy,done,data,clk,latch}", 32'(outs()), 32'(e));
        idle = !act || (d > FRAME_LEN);
        if (idle && i_start && i_en) begin
          act = 1'b1; s = t; f = i_frame; last = i_frame; ic = 0;
        end
`ifdef DISPLAY_AUTO_REFRESH_EN
        else if (idle && i_en && !i_start) begin
          ic++;
          if (ic == RC) begin
            act = 1'b1; s = t; f = last; ic = 0;
          end
        end else begin
          ic = 0;
        end
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin : stim
    cyc(3);
    chk("reset_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    i_en    = 1'b1;

    // Single reference frame, frame input scrambled right after capture
    cyc(7);
    i_frame = 32'hA5C3_0F81; i_start = 1'b1;
    cyc(1);
    i_start = 1'b0; i_frame = $urandom;
    cyc(FRAME_LEN + 15);

    // Start held high: back-to-back frames
    i_frame = 32'hFFFF_0000; i_start = 1'b1;
    cyc(3 * (FRAME_LEN + 1) + 5);
    i_start = 1'b0;
    cyc(FRAME_LEN + 5);

    // Start with enable low is ignored
    i_en = 1'b0; i_start = 1'b1;
    cyc(20);
    chk("en0_no_frame", 32'(o_busy), 32'd0);
    i_start = 1'b0; i_en = 1'b1;
    cyc(2);

    // Enable dropped at bit 5 does not abort
    i_frame = $urandom; i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    cyc(5 * DIV + 2);
    i_en = 1'b0;
    cyc(FRAME_LEN);
    i_en = 1'b1;
    cyc(5);

    // Asynchronous reset during bit 12, restart on the first cycle after release
    i_frame = $urandom; i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    cyc(12 * DIV + 2);
    #2 i_reset = 1'b1;
    #1 chk("async_reset_outs", 32'(outs()), 32'd0);
    cyc(2);
    i_reset = 1'b0; i_frame = $urandom; i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    cyc(FRAME_LEN + 5);

    // All-ones frame, then input cleared
    i_frame = 32'hFFFF_FFFF; i_start = 1'b1;
    cyc(1);
    i_start = 1'b0; i_frame = 32'h0;
    cyc(FRAME_LEN + 3);

    // Known frame then long idle (refresh or silence depending on build)
    i_frame = 32'h1234_5678; i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    cyc(FRAME_LEN + RC + FRAME_LEN + 20);

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      i_start = ($urandom_range(0, 9) == 0);
      i_en    = ($urandom_range(0, 7) != 0);
      i_frame = $urandom;
      i_reset = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    i_reset = 1'b0; i_start = 1'b0; i_en = 1'b1;
    cyc(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
